// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared definitions for the DCT/threshold/RLE chain
package rle_pkg;

    localparam int VAL_W = 12;
    localparam int CNT_W = 3;
    localparam int SYM_W = VAL_W + CNT_W;

    typedef struct packed {
        logic [CNT_W-1:0]        cnt;
        logic signed [VAL_W-1:0] val;
    } rle_sym_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rle_state_e;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - small output FIFO with registered count and full/empty flags
module word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // Space is judged on the registered count, so a same-cycle pop never frees room for a push.
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem_q[rd_q];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PTR_ONE;
        end
        if (do_pop) rd_d = rd_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rle_word_packer.sv
// rtl/rle_word_packer.sv - packs RLE symbols LSB-first into fixed words with flush-terminated records
module rle_word_packer
    import rle_pkg::*;
#(
    parameter int VAL_W      = rle_pkg::VAL_W,
    parameter int CNT_W      = rle_pkg::CNT_W,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [VAL_W-1:0]  sym_value,
    input  logic [CNT_W-1:0]  sym_count,
    input  logic              flush,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last,
    output logic              busy
);

    localparam int SYM_BITS = VAL_W + CNT_W;
    localparam int ACC_W    = 2 * WORD_W;
    localparam int FILL_W   = $clog2(WORD_W + SYM_BITS + 1);
    localparam logic [FILL_W-1:0] WORD_F = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] SYM_F  = FILL_W'(SYM_BITS);

    rle_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [ACC_W-1:0]  sym_ext;
    logic [WORD_W-1:0] pad_mask;
    logic              push;
    logic [WORD_W:0]   push_data;
    logic [WORD_W:0]   head;
    logic              fifo_full, fifo_empty;
    logic              sym_fire;

    assign sym_ready  = (state_q == RUN) && (fill_q <= WORD_F);
    assign sym_fire   = sym_valid && sym_ready;
    assign word_valid = !fifo_empty;
    assign word_last  = head[WORD_W];
    assign word_data  = head[WORD_W-1:0];
    assign busy       = (state_q == FLUSH) || !fifo_empty || (fill_q != '0);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        push      = 1'b0;
        push_data = '0;
        sym_ext   = ACC_W'({sym_count, sym_value});
        pad_mask  = ~({WORD_W{1'b1}} << fill_q);

        // Full words leave only when strictly more than a word is held, so a remainder always survives.
        if (!fifo_full && (fill_q > WORD_F)) begin
            push      = 1'b1;
            push_data = {1'b0, acc_q[WORD_W-1:0]};
            acc_d     = acc_q >> WORD_W;
            fill_d    = fill_q - WORD_F;
        end

        case (state_q)
            RUN: begin
                if (sym_fire) begin
                    acc_d  = acc_d | (sym_ext << fill_q);
                    fill_d = fill_d + SYM_F;
                end
                if (flush && (fill_d != '0)) state_d = FLUSH;
            end
            FLUSH: begin
                if (fill_q == '0) begin
                    state_d = RUN;
                end else if (!fifo_full && (fill_q <= WORD_F)) begin
                    push      = 1'b1;
                    push_data = {1'b1, acc_q[WORD_W-1:0] & pad_mask};
                    acc_d     = '0;
                    fill_d    = '0;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            acc_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
        end
    end

    word_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (word_valid && word_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/rle_word_packer.md
# rle_word_packer

Packs the variable-rate run-length symbol stream (12-bit signed DCT coefficient plus 3-bit run counter) from the RLE stage into fixed 32-bit words for the storage/transmit link. It sits directly downstream of the DCT → threshold → RLE chain. It provides:
- a valid/ready handshake on both sides;
- a small output FIFO;
- a flush command that closes a compressed record with a zero-padded final word marked `word_last`.

## Interface
Parameters:
- `VAL_W`, 12: coefficient width.
- `CNT_W`, 3: run-counter width.
- `WORD_W`, 32: output word width. Must satisfy `WORD_W ≥ VAL_W+CNT_W`.
- `FIFO_DEPTH`, 4: output FIFO entries. Power of two.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `sym_valid` in 1: symbol present.
- `sym_ready` out 1: symbol accepted when `sym_valid && sym_ready`.
- `sym_value` in `VAL_W`: signed coefficient, two's complement.
- `sym_count` in `CNT_W`: run counter.
- `flush` in 1: single-cycle pulse; closes the current record.
- `word_valid` out 1: FIFO non-empty.
- `word_ready` in 1: consumer accepts the head word.
- `word_data` out `WORD_W`: head word.
- `word_last` out 1: head word ends a record.
- `busy` out 1: `state==FLUSH` OR FIFO non-empty OR `fill≠0`.

## Operation
Symbol format and accumulator:
- `SYM_W = VAL_W+CNT_W` (15). The symbol is `{sym_count, sym_value}`, with the value in the LSBs. The value is stored raw; there is no sign extension.
- Accumulator `acc` is 2·`WORD_W` bits wide; `fill` (0..`WORD_W+SYM_W`) counts valid bits.
- An accepted symbol is written at bit position `fill`, so symbols are packed LSB-first. Then `fill += SYM_W`.

`sym_ready = (state==RUN) && (fill ≤ WORD_W)`.

State RUN:
- If `fill > WORD_W` and the FIFO is not full: push `{last=0, acc[WORD_W-1:0]}`, shift `acc` right by `WORD_W`, and set `fill -= WORD_W`.
- Because the push requires strictly greater than `WORD_W`, at least one bit always remains after a push. A word is never pushed with `fill==WORD_W` in RUN.
- `flush` is sampled in RUN only. A symbol accepted in the same cycle as `flush` belongs to the closing record.
- `flush` with `fill==0` after that cycle's update: no word is emitted and the state stays RUN.
- Otherwise the state goes to FLUSH.

State FLUSH (symbols are stalled, and `flush` is ignored):
- Each cycle with FIFO space and `fill > WORD_W`: push a full word with `last=0`, as in RUN.
- Each cycle with FIFO space and `1 ≤ fill ≤ WORD_W`: push `acc[WORD_W-1:0]` with bits at `fill` and above forced to 0, and `last=1`. Then set `fill=0`, `acc=0`, and return to RUN.

FIFO:
- Stores `{last, data}`. Pop on `word_valid && word_ready`.
- A push requires the registered count to be below `FIFO_DEPTH`. A same-cycle pop does not free space for that cycle's push.
- Simultaneous push and pop when not full keeps the count unchanged.

Reset (asynchronous, any time):
- `fill=0`, `acc=0`, FIFO empty, `state=RUN`.
- Outputs: `word_valid=0`, `word_data=0`, `word_last=0`, `busy=0`.
- `sym_ready=1` once the state is RUN.
- A partial record in progress is discarded.

## Timing
- Acceptance and accumulator update happen on the same edge E.
- If that update makes `fill > WORD_W` and the FIFO has space, the push occurs on edge E+1. `word_valid` is high in the cycle after E+1. Symbol-to-word latency is 2 cycles.
- `flush` pulse on edge F with `1 ≤ fill ≤ WORD_W`: the padded `last` word is pushed on edge F+1 and is visible after F+1.
- Sustained throughput is one symbol per cycle, except one stall cycle per pushed word (`sym_ready` low while `fill > WORD_W`).
- FIFO full with `fill > WORD_W` stalls `sym_ready` indefinitely. No symbol is ever dropped.

## Structure
- Package `rle_pkg` holds the shared definitions for the DCT/threshold/RLE chain:
  - `VAL_W`, `CNT_W`, `SYM_W`;
  - `typedef struct packed {logic [CNT_W-1:0] cnt; logic signed [VAL_W-1:0] val;} rle_sym_t`;
  - the state enum `{RUN, FLUSH}`.
- Sub-module `word_fifo` (parameterised width/depth, registered count, full/empty flags) holds the output FIFO. The top level holds the accumulator, `fill`, and the FSM.

## Test plan
- Three symbols with value 0x001 and count 1 (each 0x1001), then `flush`, `word_ready=1`. Required response:
  - first word 0x48009001 with `last=0`;
  - then 0x00000400 with `last=1`.
- Single symbol with value −5 (0xFFB) and count 0, then `flush`. Required response: one word 0x00000FFB with `last=1`.
- `flush` with no symbols since reset or since the last record. Required response: no word, `busy` stays 0, `sym_ready` stays 1.
- Continuous `sym_valid`, `word_ready=0`, `FIFO_DEPTH=4`. Required response:
  - exactly 11 symbols accepted, 4 words queued, `fill=37`, `sym_ready=0`;
  - after raising `word_ready`, all words match the bit-exact reference model.
- `flush` in the same cycle as an accepted symbol while `fill=30`. Required response:
  - the symbol is included;
  - one full word with `last=0`, then a padded word holding 13 bits with `last=1`;
  - `sym_valid` is ignored during FLUSH.
- Assert `reset` low mid-record with 2 words queued. Required response: `word_valid` drops immediately; after release, the next record starts at `fill=0` with no stale data.
